// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage: classifies RV instruction formats, builds the sign-extended
// immediate and pc-relative target, and buffers results behind a registered-ready skid buffer.
module imm_decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_tgt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FmtR = 3'd0,
    FmtI = 3'd1,
    FmtS = 3'd2,
    FmtB = 3'd3,
    FmtU = 3'd4,
    FmtJ = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
    logic            illegal;
  } entry_t;

  fmt_e            dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  entry_t          dec;

  entry_t          main_q, skid_q;
  logic            main_vld_q, skid_vld_q;
  logic [CNT_W-1:0] cnt_q;

  logic in_fire, out_fire;

  // Start every format from all-sign bits, then overwrite the encoded low field.
  always_comb begin
    dec_fmt     = FmtR;
    dec_imm     = '0;
    dec_illegal = 1'b0;
    unique case (in_inst[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        dec_fmt       = FmtI;
        dec_imm       = {XLEN{in_inst[31]}};
        dec_imm[11:0] = in_inst[31:20];
      end
      7'b0100011: begin
        dec_fmt       = FmtS;
        dec_imm       = {XLEN{in_inst[31]}};
        dec_imm[11:0] = {in_inst[31:25], in_inst[11:7]};
      end
      7'b1100011: begin
        dec_fmt       = FmtB;
        dec_imm       = {XLEN{in_inst[31]}};
        dec_imm[12:0] = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt       = FmtU;
        dec_imm       = {XLEN{in_inst[31]}};
        dec_imm[31:0] = {in_inst[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt       = FmtJ;
        dec_imm       = {XLEN{in_inst[31]}};
        dec_imm[20:0] = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      7'b0110011: begin
        dec_fmt = FmtR;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    dec.imm     = dec_imm;
    dec.fmt     = dec_fmt;
    dec.pc      = in_pc;
    dec.tgt     = in_pc + dec_imm;
    dec.illegal = dec_illegal;
  end

  assign in_rdy   = !skid_vld_q;
  assign in_fire  = in_vld & in_rdy;
  assign out_fire = main_vld_q & out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (flush) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (out_fire && skid_vld_q) begin
      // in_rdy is low here, so nothing can be arriving this cycle.
      main_q     <= skid_q;
      skid_vld_q <= 1'b0;
    end else if (in_fire && (!main_vld_q || out_fire)) begin
      main_q     <= dec;
      main_vld_q <= 1'b1;
    end else if (in_fire) begin
      skid_q     <= dec;
      skid_vld_q <= 1'b1;
    end else if (out_fire) begin
      main_vld_q <= 1'b0;
    end
  end

  // Dropped flush-cycle inputs never reach the counter; already-accepted ones stay counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (in_fire && !flush && dec_illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_vld     = main_vld_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_pc      = main_q.pc;
  assign out_tgt     = main_q.tgt;
  assign out_illegal = main_q.illegal;
  assign illegal_cnt = cnt_q;

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Registered, parametrised immediate-decode stage between instruction fetch and the execute unit.
- Classifies the RV instruction format and produces a sign-extended XLEN immediate for I/S/B/U/J formats.
- Computes the PC-relative target (pc + imm) and flags unsupported opcodes.
- Valid/ready on both sides, with a one-entry skid buffer so in_rdy is a registered signal. Also supports flush and a saturating illegal-instruction counter.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Immediates are sign-extended from their top encoded bit to XLEN.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- flush  in  1  drop all buffered entries.
- in_vld  in  1  input instruction valid.
- in_rdy  out  1  stage can accept an input.
- in_inst  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address.
- out_vld  out  1  output entry valid.
- out_rdy  in  1  consumer accepts the output.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J.
- out_pc  out  XLEN  pass-through pc.
- out_tgt  out  XLEN  out_pc + out_imm, modulo 2^XLEN.
- out_illegal  out  1  unsupported opcode.
- illegal_cnt  out  CNT_W  count of accepted illegal instructions, saturating.

Behaviour:
- Reset (async on rst_n low): out_vld=0, skid valid=0, in_rdy=1, illegal_cnt=0; all data outputs=0.
- Input fire = in_vld & in_rdy. Output fire = out_vld & out_rdy.
- Format from opcode inst[6:0]:
  - I: 0000011, 0010011, 1100111, 1110011, 0001111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011, with imm=0.
  - Anything else, or inst[1:0]!=2'b11: fmt=0, imm=0, illegal=1.
- Immediate assembly, sign bit always inst[31]:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U: {inst[31:12], 12'b0}, sign-extended when XLEN=64.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
- tgt is computed for every format; the consumer uses it only for B/J/AUIPC.
- Latency: decode is combinational on the input; results are registered into the main entry, so out_vld rises 1 cycle after input fire.
- Main entry load rules:
  - Input fire with main empty, or with output fire in the same cycle and skid empty: main <= decoded input.
  - Input fire with main full and no output fire: skid <= decoded input.
  - Output fire with skid full: main <= skid, skid cleared. in_rdy is 0 in this case, so no input can fire.
- in_rdy = !skid_vld (registered state, no combinational path from out_rdy).
- While out_vld=1 and out_rdy=0, all out_* signals are held stable.
- Order is preserved; no entry is lost or duplicated.
- Flush has priority over everything else:
  - Next edge: out_vld=0, skid cleared.
  - An input firing in the flush cycle is dropped and does not count.
  - in_rdy=1 in the following cycle.
- illegal_cnt increments on each input fire whose decode is illegal, including inputs later flushed.
  - It holds at 2^CNT_W-1 and is cleared only by reset.

Test Plan:
- XLEN=32: 0xFFF00093 (addi x1,x0,-1), pc=0x0 -> out_fmt=1, out_imm=0xFFFFFFFF, out_tgt=0xFFFFFFFF, out_vld 1 cycle after input fire.
- 0xFE20AE23 (sw x2,-4(x1)) -> fmt=2, imm=0xFFFFFFFC.
- 0xFE000CE3 (beq -8) at pc=0x100 -> fmt=3, imm=0xFFFFFFF8, tgt=0xF8.
- 0x0010006F (jal +2048) at pc=0x1000 -> fmt=5, imm=0x800, tgt=0x1800.
- XLEN=64: 0x800002B7 (lui x5,0x80000) -> fmt=4, imm=0xFFFFFFFF80000000.
- Backpressure: hold out_rdy=0 and stream 3 instructions -> two accepted, in_rdy=0 after the second. Release out_rdy -> outputs appear in order, in_rdy returns to 1.
- Illegal and flush:
  - Inject 0x00000000 -> illegal=1, fmt=0, imm=0, illegal_cnt=1.
  - With CNT_W=2, five illegals -> illegal_cnt=3.
  - Flush with both entries full -> out_vld=0 and in_rdy=1 next cycle.
  - Async reset asserted mid-stream -> all outputs immediately 0.
